// File: rtl/byte_mem_responder_pkg.sv
// Shared widths, IO register map and decode types for the byte-wide memory responder.
package byte_mem_responder_pkg;
    localparam int ADDR_WID    = 32;
    localparam int DATA_WID    = 8;
    localparam int IO_BASE_BIT = 17;
    localparam int DECODE_WID  = IO_BASE_BIT + 1;

    localparam logic [DECODE_WID-1:0] UART_DATA_ADDR = 18'h30000;
    localparam logic [DECODE_WID-1:0] UART_STAT_ADDR = 18'h30004;
    localparam logic [DECODE_WID-1:0] HALT_ADDR      = 18'h30008;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_UART_DATA,
        SEL_UART_STAT,
        SEL_HALT,
        SEL_NONE
    } bus_sel_e;

    // Status register only has room for five count bits.
    function automatic logic [4:0] stat_count(input logic [31:0] cnt);
        return (cnt > 32'd31) ? 5'd31 : cnt[4:0];
    endfunction
endpackage

// File: rtl/byte_fifo.sv
// TX byte FIFO with power-of-two depth; a same-cycle pop frees the slot a push needs.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)
                count <= count + CNT_W'(1);
            else if (do_pop && !do_push)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/byte_mem_responder.sv
// Byte-bus responder: 1-cycle-latency main RAM plus UART TX FIFO in the IO window.
// Define IO_HALT_EN to add the sticky sim_halt register at the HALT offset.
module byte_mem_responder
    import byte_mem_responder_pkg::*;
#(
    parameter int RAM_ADDR_WID = 17,
    parameter int FIFO_DEPTH   = 16,
    parameter int FULL_MARGIN  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic [ADDR_WID-1:0] mem_a,
    input  logic [DATA_WID-1:0] mem_dout,
    input  logic                mem_wr,
    output logic [DATA_WID-1:0] mem_din,
    output logic                io_buffer_full,
    output logic                tx_valid,
    output logic [DATA_WID-1:0] tx_data,
    input  logic                tx_ready
`ifdef IO_HALT_EN
    ,
    output logic                sim_halt
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WID-1:0] ram [0:(2**RAM_ADDR_WID)-1];
    bus_sel_e            sel;
    logic                overflow;
    logic                halted;
    logic                uart_push;
    logic                fifo_push;
    logic                pop;
    logic                stat_wr;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W-1:0]    count_next;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^mem_a[ADDR_WID-1:DECODE_WID];

    always_comb begin
        sel = SEL_RAM;
        if (mem_a[IO_BASE_BIT]) begin
            case (mem_a[DECODE_WID-1:0])
                UART_DATA_ADDR: sel = SEL_UART_DATA;
                UART_STAT_ADDR: sel = SEL_UART_STAT;
                HALT_ADDR:      sel = SEL_HALT;
                default:        sel = SEL_NONE;
            endcase
        end
    end

`ifdef IO_HALT_EN
    assign halted = sim_halt;

    always_ff @(posedge clk) begin
        if (!rst)
            sim_halt <= 1'b0;
        else if (rdy && mem_wr && sel == SEL_HALT)
            sim_halt <= 1'b1;
    end
`else
    assign halted = 1'b0;
`endif

    assign pop        = rdy && tx_valid && tx_ready;
    assign uart_push  = rdy && mem_wr && (sel == SEL_UART_DATA) && !halted;
    assign fifo_push  = uart_push && (!fifo_full || pop);
    assign stat_wr    = rdy && mem_wr && (sel == SEL_UART_STAT);
    assign count_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(pop);
    assign tx_valid   = !fifo_empty;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (mem_dout),
        .pop   (pop),
        .dout  (tx_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // RAM contents survive reset; only the bus-facing registers clear.
    always_ff @(posedge clk) begin
        if (rst && rdy && mem_wr && sel == SEL_RAM)
            ram[mem_a[RAM_ADDR_WID-1:0]] <= mem_dout;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_din        <= '0;
            io_buffer_full <= 1'b0;
            overflow       <= 1'b0;
        end else if (rdy) begin
            io_buffer_full <= 32'(count_next) >= 32'(FIFO_DEPTH - FULL_MARGIN);
            if (uart_push && !fifo_push)
                overflow <= 1'b1;
            else if (stat_wr)
                overflow <= 1'b0;
            if (!mem_wr) begin
                case (sel)
                    SEL_RAM:       mem_din <= ram[mem_a[RAM_ADDR_WID-1:0]];
                    SEL_UART_STAT: mem_din <= {overflow, 2'b00, stat_count(32'(fifo_count))};
                    default:       mem_din <= '0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_byte_mem_responder.sv
// Bench for byte_mem_responder: directed scenarios then random traffic against a queue-based model.
module tb_byte_mem_responder;
    localparam int DEPTH  = 16;
    localparam int MARGIN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
`ifdef IO_HALT_EN
    logic        sim_halt;
`endif

    always #5 clk = ~clk;

    byte_mem_responder dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready)
`ifdef IO_HALT_EN
        ,
        .sim_halt       (sim_halt)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] m_ram [0:131071];
    logic [7:0] m_q [$];
    logic [7:0] m_din;
    logic       m_ovf;
    logic       m_full;
    logic       m_halt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one clock edge, in terms of the register map and a byte queue.
    task automatic model_update();
        logic [17:0] a;
        int          cnt;
        if (!rst) begin
            m_din = 8'h00; m_q.delete(); m_ovf = 1'b0; m_full = 1'b0; m_halt = 1'b0;
            return;
        end
        if (!rdy) return;
        a   = mem_a[17:0];
        cnt = m_q.size();
        if (!mem_wr) begin
            if (!a[17])             m_din = m_ram[a[16:0]];
            else if (a == 18'h30004) m_din = {m_ovf, 2'b00, 5'((cnt > 31) ? 31 : cnt)};
            else                    m_din = 8'h00;
        end else if (!a[17]) begin
            m_ram[a[16:0]] = mem_dout;
        end
        if (tx_ready && cnt > 0) void'(m_q.pop_front());
        if (mem_wr && a == 18'h30000 && !m_halt) begin
            if (m_q.size() < DEPTH) m_q.push_back(mem_dout);
            else                    m_ovf = 1'b1;
        end
        if (mem_wr && a == 18'h30004) m_ovf = 1'b0;
`ifdef IO_HALT_EN
        if (mem_wr && a == 18'h30008) m_halt = 1'b1;
`endif
        m_full = (m_q.size() >= DEPTH - MARGIN);
    endtask

    task automatic check_outputs(input string ph);
        chk({ph, ".mem_din"}, 32'(mem_din), 32'(m_din));
        chk({ph, ".tx_valid"}, 32'(tx_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk({ph, ".tx_data"}, 32'(tx_data), 32'(m_q[0]));
        chk({ph, ".io_buffer_full"}, 32'(io_buffer_full), 32'(m_full));
`ifdef IO_HALT_EN
        chk({ph, ".sim_halt"}, 32'(sim_halt), 32'(m_halt));
`endif
    endtask

    task automatic cycle(input logic r, input logic y, input logic [31:0] a, input logic [7:0] d,
                         input logic w, input logic tr, input string ph);
        rst = r; rdy = y; mem_a = a; mem_dout = d; mem_wr = w; tx_ready = tr;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs(ph);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        logic [31:0] hi;
        logic [17:0] lo;
        r  = $urandom;
        hi = ($urandom_range(0, 3) == 0) ? {r[31:18], 18'd0} : 32'd0;
        case ($urandom_range(0, 6))
            0, 1:    lo = (($urandom_range(0, 1) == 1) ? 18'h00100 : 18'h1FFF0) + 18'($urandom_range(0, 15));
            2, 3:    lo = 18'h30000;
            4:       lo = 18'h30004;
            5:       lo = 18'h30008;
            default: lo = 18'h20000 | 18'($urandom_range(0, 18'h1FFFF));
        endcase
        return hi | 32'(lo);
    endfunction

    initial begin
        logic [7:0] plan_rd [4];
        plan_rd = '{8'h13, 8'h05, 8'h10, 8'h00};

        cycle(0, 1, 32'h0, 8'h00, 0, 0, "rst");
        cycle(0, 1, 32'h0, 8'h00, 0, 0, "rst");
        chk("rst.mem_din_zero", 32'(mem_din), 32'h0);
        chk("rst.tx_valid_zero", 32'(tx_valid), 32'h0);

        for (int i = 0; i < 16; i++) begin
            cycle(1, 1, 32'h100 + 32'(i), 8'($urandom), 1, 0, "init");
            cycle(1, 1, 32'h1FFF0 + 32'(i), 8'($urandom), 1, 0, "init");
        end
        cycle(1, 1, 32'h200, 8'h11, 1, 0, "init");
        for (int i = 0; i < 4; i++) cycle(1, 1, 32'h100 + 32'(i), plan_rd[i], 1, 0, "preload");

        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 32'h100 + 32'(i), 8'h00, 0, 0, "ramrd");
            chk("ramrd.plan", 32'(mem_din), 32'(plan_rd[i]));
        end

        cycle(1, 1, 32'h1FFFF, 8'hA5, 1, 0, "raw");
        cycle(1, 1, 32'h1FFFF, 8'h00, 0, 0, "raw");
        chk("raw.a5", 32'(mem_din), 32'hA5);
        cycle(1, 1, 32'h3FFFF, 8'h00, 0, 0, "io_unmapped");
        chk("io_unmapped.zero", 32'(mem_din), 32'h0);
        cycle(1, 1, 32'hFFFC0100, 8'h00, 0, 0, "alias");
        chk("alias.ram", 32'(mem_din), 32'h13);

        cycle(1, 0, 32'h200, 8'hEE, 1, 0, "rdy_low");
        cycle(1, 1, 32'h200, 8'h00, 0, 0, "rdy_low");
        chk("rdy_low.ram_kept", 32'(mem_din), 32'h11);

        for (int i = 0; i < 14; i++) begin
            cycle(1, 1, 32'h30000, 8'(8'h40 + i), 1, 0, "fill");
            chk("fill.full_flag", 32'(io_buffer_full), 32'(i == 13));
        end
        for (int i = 0; i < 3; i++) cycle(1, 1, 32'h30000, 8'(8'h60 + i), 1, 0, "over");
        cycle(1, 1, 32'h30004, 8'h00, 0, 0, "stat");
        chk("stat.0x90", 32'(mem_din), 32'h90);

        cycle(1, 1, 32'h30004, 8'h00, 1, 0, "ovf_clr");
        for (int i = 0; i < 4; i++) cycle(1, 1, 32'h30000, 8'(8'h70 + i), 1, 1, "pushpop");
        cycle(1, 1, 32'h30004, 8'h00, 0, 0, "stat2");
        chk("stat2.0x10", 32'(mem_din), 32'h10);

        for (int i = 0; i < 18; i++) cycle(1, 1, 32'h100, 8'h00, 0, 1, "drain");
        chk("drain.empty", 32'(tx_valid), 32'h0);

        for (int i = 0; i < 5; i++) cycle(1, 1, 32'h30000, 8'(i), 1, 0, "midfill");
        cycle(0, 1, 32'h30000, 8'hFF, 1, 0, "midrst");
        chk("midrst.tx_valid", 32'(tx_valid), 32'h0);
        chk("midrst.full", 32'(io_buffer_full), 32'h0);
        cycle(1, 1, 32'h1FFFF, 8'h00, 0, 0, "retain");
        chk("retain.a5", 32'(mem_din), 32'hA5);

`ifdef IO_HALT_EN
        cycle(1, 1, 32'h30008, 8'h01, 1, 0, "halt");
        chk("halt.set", 32'(sim_halt), 32'h1);
        cycle(1, 1, 32'h30000, 8'h55, 1, 0, "halt_push");
        chk("halt_push.ignored", 32'(tx_valid), 32'h0);
        cycle(0, 1, 32'h0, 8'h00, 0, 0, "halt_rst");
`endif

        for (int i = 0; i < 3000; i++) begin
            logic tr;
            tr = ((i / 150) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) != 0), rand_addr(),
                  8'($urandom), 1'($urandom_range(0, 1)), tr, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
